// File: rtl/apb_cmd_master_if.sv
// Command/response handshake and APB bus bundle for apb_cmd_master.
// The master modport is the initiator view; the slave modport is the view of the command source and APB target.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_tmo;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB initiator: one valid/ready command becomes one SETUP/ACCESS transfer and one response.
// Optional ACCESS wait-state abort is compiled in with APB_MASTER_TIMEOUT_EN (TIMEOUT then sets the limit).
module apb_cmd_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
`ifdef APB_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input logic              PCLK,
  input logic              PRESET,
  apb_cmd_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              pwrite_reg, pwrite_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic [DATA_W-1:0] pwdata_reg, pwdata_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_err_reg, rsp_err_next;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic              rsp_tmo_reg, rsp_tmo_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg     <= IDLE;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_tmo_reg   <= 1'b0;
      wait_cnt_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_tmo_reg   <= rsp_tmo_next;
      wait_cnt_reg  <= wait_cnt_next;
`endif
    end
  end

  // The APB output registers double as the command latch, so the bus is driven straight from flops.
  always_comb begin
    state_next     = state_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
`ifdef APB_MASTER_TIMEOUT_EN
    rsp_tmo_next   = rsp_tmo_reg;
    wait_cnt_next  = wait_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_next   = SETUP;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          pwrite_next  = bus.cmd_write;
          paddr_next   = bus.cmd_addr;
          pwdata_next  = bus.cmd_write ? bus.cmd_wdata : '0;
        end
      end

      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_next = '0;
`endif
      end

      ACCESS: begin
        if (bus.PREADY) begin
          state_next     = RESP;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          pwrite_next    = 1'b0;
          paddr_next     = '0;
          pwdata_next    = '0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = pwrite_reg ? '0 : bus.PRDATA;
          rsp_err_next   = bus.PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_tmo_next   = 1'b0;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          // Slave held PREADY low for the whole budget: abandon the transfer.
          state_next     = RESP;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          pwrite_next    = 1'b0;
          paddr_next     = '0;
          pwdata_next    = '0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          rsp_tmo_next   = 1'b1;
        end else begin
          wait_cnt_next  = wait_cnt_reg + 1'b1;
`endif
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_tmo_next   = 1'b0;
`endif
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (state_reg == IDLE);
  assign bus.PSEL      = psel_reg;
  assign bus.PENABLE   = penable_reg;
  assign bus.PWRITE    = pwrite_reg;
  assign bus.PADDR     = paddr_reg;
  assign bus.PWDATA    = pwdata_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
`ifdef APB_MASTER_TIMEOUT_EN
  assign bus.rsp_tmo   = rsp_tmo_reg;
`else
  assign bus.rsp_tmo   = 1'b0;
`endif

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

- Synthesizable APB initiator that turns single read/write commands on a valid/ready port into APB SETUP/ACCESS transfers toward the UART APB slaves.
- Returns read data and error status on a valid/ready response port.
- Sits between a local controller (CPU-less sequencer, loader or test harness) and the UART register space at word addresses 0x000–0x005 plus per-instance offsets.
- Replaces bench-only APB driving with a reusable hardware master.

## Interface
- ADDR_W, 10, width of PADDR (word address bits [11:2])
- DATA_W, 32, width of PWDATA/PRDATA and command/response data
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort (≥2; used only with timeout compiled in)

Ports:
- PCLK  in  1  single clock, all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target word address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers
- rsp_err  out  1  PSLVERR seen, or timeout
- rsp_tmo  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  slave ready / wait-state control
- PSLVERR  in  1  slave error, sampled with PREADY

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - cmd_valid=1 → latch write, address and data (wdata forced 0 for reads) → SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the latched command → ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1, address, data and control held stable.
  - PREADY=1 → capture PRDATA (reads only, else 0) and PSLVERR into rsp_err, rsp_tmo=0 → RESP.
  - PREADY=0 → stay in ACCESS (wait state).
- RESP:
  - PSEL=PENABLE=0, PADDR/PWDATA/PWRITE driven 0.
  - rsp_valid=1 with rsp_rdata, rsp_err and rsp_tmo held stable until rsp_ready=1 → IDLE.
- cmd_ready is 0 in SETUP, ACCESS and RESP; at most one outstanding transfer.
- Outside SETUP/ACCESS, all APB outputs are 0.
- PSLVERR is ignored unless PREADY=1 in ACCESS.

## Timing
- All APB outputs, rsp_* and the FSM state are registered. cmd_ready is decoded from state only.
- Reset: while PRESET=1, state←IDLE and every registered output←0 at each edge; cmd_valid is ignored. cmd_ready=1 from the first cycle after release.
- Zero-wait read: accept at edge N; SETUP during N+1; ACCESS during N+2 (PREADY=1 sampled at edge N+3); rsp_valid=1 during N+3.
- Each PREADY=0 ACCESS cycle adds one cycle of latency.
- With rsp_ready held 1, back-to-back throughput is one transfer per 4 cycles.
- Reset mid-transfer: PSEL/PENABLE drop at the next edge; the transfer is discarded and no response is issued.
- A command arriving while in RESP stays pending (cmd_ready=0) until IDLE.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When PREADY=0 and counter==TIMEOUT-1, go to RESP with rsp_err=1, rsp_tmo=1, rsp_rdata=0; PSEL/PENABLE drop at that edge.
  - PREADY=1 on the abort cycle wins (normal completion).
- APB_MASTER_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; rsp_tmo is tied 0.

## Test plan
- Write 0x002 data 0x3F, PREADY tied 1 → PSEL/PWRITE=1 and PADDR=0x002 for 2 cycles, PENABLE=1 on the 2nd; rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read 0x001, slave returns 0x0000_0005 after 3 PREADY=0 wait states → PADDR stable for 5 cycles; rsp_rdata=0x5 at accept+6.
- Write with PSLVERR=1 and PREADY=1 → rsp_err=1, rsp_tmo=0. Read with PSLVERR=1 and PREADY=0 → error ignored until PREADY.
- Hold rsp_ready=0 for 10 cycles in RESP with cmd_valid=1 → response stable and cmd_ready=0 throughout; next command accepted the cycle after rsp_ready=1.
- Assert PRESET during ACCESS → PSEL=PENABLE=0 next cycle, no rsp_valid, cmd_ready=1 after release.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT=16, PREADY stuck 0 → abort after 16 ACCESS cycles with rsp_err=rsp_tmo=1, rsp_rdata=0. PREADY=1 on the 16th cycle → normal completion.
